// File: rtl/osc_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : osc_envelope
//  Purpose  : ADSR amplitude envelope applied to the 16-bit signed sine
//             oscillator output. A gate input drives the envelope through
//             IDLE/ATTACK/DECAY/SUSTAIN/RELEASE. Each sample is scaled by the
//             current envelope level, with one clock of latency.
//  Options  : ENV_EXP_RELEASE_EN - when defined, RELEASE is exponential: each
//             tick subtracts max(level>>4, 1). When undefined, RELEASE is
//             linear and subtracts RELEASE_STEP per tick.
//  Revision : 1.0 - initial release
// ============================================================================
module osc_envelope #(
    parameter int          TICK_DIV      = 1000,
    parameter logic [15:0] ATTACK_STEP   = 16'd66,
    parameter logic [15:0] DECAY_STEP    = 16'd33,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hA000,
    parameter logic [15:0] RELEASE_STEP  = 16'd22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic [15:0] level,
    output logic [2:0]  state,
    output logic        busy
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state_q;
    logic [15:0]        level_q;
    logic [15:0]        sample_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick;

    // Saturating level arithmetic, evaluated from the current level.
    logic [16:0]        att_sum_d;
    logic [15:0]        att_sat_d;
    logic [16:0]        dec_diff_d;
    logic [15:0]        dec_sat_d;
    logic [15:0]        rel_step_d;
    logic [15:0]        rel_sat_d;
    logic               rel_done_d;

    // Gain path: signed sample times non-negative level.
    logic signed [32:0] product;
    logic               prod_unused;

    assign tick = (cnt_q == CNT_MAX);

    // Free-running envelope tick divider; the gate has no effect on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Candidate next levels for each ramp, clamped to [0, FFFF].
    always_comb begin
        att_sum_d  = {1'b0, level_q} + {1'b0, ATTACK_STEP};
        att_sat_d  = att_sum_d[16] ? 16'hFFFF : att_sum_d[15:0];
        dec_diff_d = {1'b0, level_q} - {1'b0, DECAY_STEP};
        dec_sat_d  = dec_diff_d[16] ? 16'h0000 : dec_diff_d[15:0];
`ifdef ENV_EXP_RELEASE_EN
        rel_step_d = (level_q[15:4] == 12'd0) ? 16'd1 : {4'd0, level_q[15:4]};
`else
        rel_step_d = RELEASE_STEP;
`endif
        // Reaching or passing zero ends the release.
        rel_done_d = (level_q <= rel_step_d);
        rel_sat_d  = rel_done_d ? 16'h0000 : (level_q - rel_step_d);
    end

    // Envelope state machine; gate events take priority over tick-driven ramps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            level_q <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            if ((state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN) && !gate) begin
                state_q <= S_RELEASE;
                busy_q  <= 1'b1;
            end else if (state_q == S_IDLE && gate) begin
                state_q <= S_ATTACK;
                level_q <= 16'h0000;
                busy_q  <= 1'b1;
            end else if (state_q == S_RELEASE && gate) begin
                // Retrigger continues from the present level to avoid a click.
                state_q <= S_ATTACK;
                busy_q  <= 1'b1;
            end else if (tick) begin
                case (state_q)
                    S_ATTACK: begin
                        if (att_sum_d >= 17'h0FFFF) begin
                            level_q <= 16'hFFFF;
                            state_q <= S_DECAY;
                        end else begin
                            level_q <= att_sat_d;
                        end
                    end
                    S_DECAY: begin
                        if (dec_sat_d <= SUSTAIN_LEVEL) begin
                            level_q <= SUSTAIN_LEVEL;
                            state_q <= S_SUSTAIN;
                        end else begin
                            level_q <= dec_sat_d;
                        end
                    end
                    S_SUSTAIN: begin
                        level_q <= SUSTAIN_LEVEL;
                    end
                    S_RELEASE: begin
                        level_q <= rel_sat_d;
                        if (rel_done_d) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        // Idle with gate low: nothing to do.
                    end
                endcase
            end
        end
    end

    assign product     = $signed(sample_in) * $signed({1'b0, level_q});
    assign prod_unused = ^{product[32], product[15:0]};

    // Registered gain output; arithmetic >>>16 is the product's [31:16] slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 16'h0000;
        end else begin
            sample_q <= product[31:16];
        end
    end

    assign sample_out = sample_q;
    assign level      = level_q;
    assign state      = state_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osc_envelope
//  Purpose  : Self-checking bench for osc_envelope: directed ADSR scenarios
//             followed by random gate/sample traffic compared against a
//             behavioural envelope model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_osc_envelope;

    localparam int          P_TICK = 4;
    localparam logic [15:0] P_ATT  = 16'h4000;
    localparam logic [15:0] P_DEC  = 16'h2000;
    localparam logic [15:0] P_SUS  = 16'hA000;
    localparam logic [15:0] P_REL  = 16'h5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic [15:0] level;
    logic [2:0]  state;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    osc_envelope #(
        .TICK_DIV      (P_TICK),
        .ATTACK_STEP   (P_ATT),
        .DECAY_STEP    (P_DEC),
        .SUSTAIN_LEVEL (P_SUS),
        .RELEASE_STEP  (P_REL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .gate       (gate),
        .sample_in  (sample_in),
        .sample_out (sample_out),
        .level      (level),
        .state      (state),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: envelope as integer arithmetic on an ADSR phase.
    // ------------------------------------------------------------------
    int          m_cnt;
    logic [2:0]  m_state;
    logic [15:0] m_level;
    logic [15:0] m_out;

    function automatic logic [18:0] next_env(input logic [2:0] st, input logic [15:0] lv_in,
                                             input bit tk, input logic g);
        int s;
        int lv;
        int d;
        s  = int'(st);
        lv = int'(lv_in);
        d  = 0;
        if (s >= 1 && s <= 3 && !g) begin
            s = 4;
        end else if (s == 0 && g) begin
            s  = 1;
            lv = 0;
        end else if (s == 4 && g) begin
            s = 1;
        end else if (tk) begin
            if (s == 1) begin
                lv = lv + int'(P_ATT);
                if (lv >= 65535) begin
                    lv = 65535;
                    s  = 2;
                end
            end else if (s == 2) begin
                lv = lv - int'(P_DEC);
                if (lv <= int'(P_SUS)) begin
                    lv = int'(P_SUS);
                    s  = 3;
                end
            end else if (s == 3) begin
                lv = int'(P_SUS);
            end else if (s == 4) begin
`ifdef ENV_EXP_RELEASE_EN
                d = lv / 16;
                if (d < 1) d = 1;
`else
                d = int'(P_REL);
`endif
                lv = lv - d;
                if (lv <= 0) begin
                    lv = 0;
                    s  = 0;
                end
            end
        end
        return {3'(s), 16'(lv)};
    endfunction

    function automatic logic [15:0] gain(input logic [15:0] s, input logic [15:0] lv);
        longint p;
        p = longint'($signed(s)) * longint'(lv);
        return 16'(p >>> 16);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_state <= 3'd0;
            m_level <= 16'h0000;
            m_out   <= 16'h0000;
        end else begin
            m_cnt              <= (m_cnt == P_TICK - 1) ? 0 : m_cnt + 1;
            {m_state, m_level} <= next_env(m_state, m_level, (m_cnt == P_TICK - 1), gate);
            m_out              <= gain(sample_in, m_level);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the level to move, then check the new level/state.
    task automatic wait_lvl(input logic [15:0] exp_lv, input logic [2:0] exp_st, input string tag);
        logic [15:0] prev;
        int n;
        prev = level;
        n    = 0;
        while (level == prev && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " level"}, 32'(level), 32'(exp_lv));
        chk({tag, " state"}, 32'(state), 32'(exp_st));
    endtask

    task automatic wait_state(input logic [2:0] exp_st, input int budget, input string tag);
        int n;
        n = 0;
        while (state != exp_st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state), 32'(exp_st));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        gate      = 1'b1;
        sample_in = 16'h4000;
        repeat (3) @(negedge clk);
        chk("rst sample_out", 32'(sample_out), 32'h0);
        chk("rst level",      32'(level),      32'h0);
        chk("rst state",      32'(state),      32'h0);
        chk("rst busy",       32'(busy),       32'h0);

        rst = 1'b0;
        @(negedge clk);
        chk("post-rst state", 32'(state), 32'd1);
        chk("post-rst busy",  32'(busy),  32'd1);

        // Attack ramp with gain checks at two reference levels.
        wait_lvl(16'h4000, 3'd1, "att1");
        wait_lvl(16'h8000, 3'd1, "att2");
        sample_in = 16'h4000;
        @(negedge clk);
        chk("gain 4000x8000", 32'(sample_out), 32'h2000);
        sample_in = 16'hC000;
        @(negedge clk);
        chk("gain C000x8000", 32'(sample_out), 32'hE000);
        wait_lvl(16'hC000, 3'd1, "att3");
        wait_lvl(16'hFFFF, 3'd2, "att-peak");
        sample_in = 16'h4000;
        @(negedge clk);
        chk("gain 4000xFFFF", 32'(sample_out), 32'h3FFF);

        // Decay into sustain.
        wait_lvl(16'hDFFF, 3'd2, "dec1");
        wait_lvl(16'hBFFF, 3'd2, "dec2");
        wait_lvl(16'hA000, 3'd3, "sustain");
        repeat (6) @(negedge clk);
        chk("sustain hold", 32'(level), 32'hA000);

        // Release, then retrigger mid-release.
        gate = 1'b0;
        @(negedge clk);
        chk("rel enter state", 32'(state), 32'd4);
        chk("rel enter busy",  32'(busy),  32'd1);
        chk("rel enter level", 32'(level), 32'hA000);
`ifdef ENV_EXP_RELEASE_EN
        wait_lvl(16'h9600, 3'd4, "rel1");
`else
        wait_lvl(16'h5000, 3'd4, "rel1");
`endif
        gate = 1'b1;
        @(negedge clk);
        chk("retrig state", 32'(state), 32'd1);
`ifdef ENV_EXP_RELEASE_EN
        wait_lvl(16'hD600, 3'd1, "retrig");
`else
        wait_lvl(16'h9000, 3'd1, "retrig");
`endif
        wait_state(3'd3, 100, "retrig sustain");

        // Full release to idle.
        gate = 1'b0;
        @(negedge clk);
        chk("rel2 state", 32'(state), 32'd4);
`ifdef ENV_EXP_RELEASE_EN
        wait_lvl(16'h9600, 3'd4, "rel2a");
        wait_state(3'd0, 2000, "rel2 idle");
        chk("rel2 level", 32'(level), 32'h0);
`else
        wait_lvl(16'h5000, 3'd4, "rel2a");
        wait_lvl(16'h0000, 3'd0, "rel2b");
`endif
        chk("rel2 busy", 32'(busy), 32'h0);

        // Random traffic against the model, with one mid-note async reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            chk("rnd sample_out", 32'(sample_out), 32'(m_out));
            chk("rnd level",      32'(level),      32'(m_level));
            chk("rnd state",      32'(state),      32'(m_state));
            chk("rnd busy",       32'(busy),       32'(m_state != 3'd0));
            rst = (i == 2000);
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            sample_in = 16'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
